// File: rtl/nash_axil_arbiter.sv
// nash_axil_arbiter: shares one AXI4-Lite master port among NREQ requesters.
// Each requester issues single-beat reads/writes over valid/grant/done; one
// AXI transaction is outstanding at a time.
// Build option: define NASH_AXIL_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default is round-robin.
module nash_axil_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_grant,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic [ADDR_W-1:0]        M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [DATA_W-1:0]        M_AXI_WDATA,
  output logic [DATA_W/8-1:0]      M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [ADDR_W-1:0]        M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [DATA_W-1:0]        M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] S_WR_RESP      = 3'd2;
  localparam logic [2:0] S_RD_ADDR      = 3'd3;
  localparam logic [2:0] S_RD_DATA      = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [IDX_W-1:0]  win_q,     win_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              bready_q,  bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q,  rready_d;
  logic [NREQ-1:0]   grant_q,   grant_d;
  logic [NREQ-1:0]   done_q,    done_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [1:0]        resp_q,    resp_d;

  logic              found_c;
  logic [IDX_W-1:0]  pick_c;
  logic [IDX_W-1:0]  cand_c;
  logic              aw_fin_c;
  logic              w_fin_c;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  // Unpack the flat per-requester address/data buses
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

`ifdef NASH_AXIL_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index pending requester wins
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      cand_c = IDX_W'(i);
      if (req_valid[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_q, last_d;

  // Round-robin: first pending requester after the last winner
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand_c = IDX_W'((int'(last_q) + k) % int'(NREQ));
      if (req_valid[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  // Round-robin pointer; reset value makes requester 0 win first
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) last_q <= IDX_W'(NREQ - 1);
    else          last_q <= last_d;
  end

  // Pointer follows each accepted grant
  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && found_c) last_d = pick_c;
  end
`endif

  // State and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    grant_d   = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_fin_c  = 1'b0;
    w_fin_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d           = pick_c;
          addr_d          = addr_arr[pick_c];
          wdata_d         = wdata_arr[pick_c];
          grant_d[pick_c] = 1'b1;
          if (req_we[pick_c]) begin
            state_d   = S_WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_ADDR_DATA: begin
        // AW and W retire independently; a channel is finished once its valid is gone
        aw_fin_c = !awvalid_q || M_AXI_AWREADY;
        w_fin_c  = !wvalid_q  || M_AXI_WREADY;
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q  && M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (aw_fin_c && w_fin_c) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d        = M_AXI_BRESP;
          done_d[win_q] = 1'b1;
          bready_d      = 1'b0;
          state_d       = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d       = M_AXI_RDATA;
          resp_d        = M_AXI_RRESP;
          done_d[win_q] = 1'b1;
          rready_d      = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  assign req_grant     = grant_q;
  assign req_done      = done_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {STRB_W{1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_nash_axil_arbiter.sv
// Bench for nash_axil_arbiter: table of single transactions, a held-request
// arbitration sequence and a mid-transaction reset, against an AXI-Lite slave model.
module tb_nash_axil_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic                   ARESETN;
  logic [NREQ-1:0]        req_valid, req_we, req_grant, req_done;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [1:0]             rsp_resp;
  logic [ADDR_W-1:0]      M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]             M_AXI_AWPROT, M_AXI_ARPROT;
  logic                   M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic [DATA_W-1:0]      M_AXI_WDATA;
  logic [DATA_W/8-1:0]    M_AXI_WSTRB;
  logic                   M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic                   M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]             M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [DATA_W-1:0]      M_AXI_RDATA = '0;

  nash_axil_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(tb_ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0;
  logic [1:0]  xresp = 2'b00;
  bit          b_hold = 1'b0;
  logic [31:0] mem [0:63];
  int          aw_cnt = 0, w_cnt = 0;
  bit          aw_seen = 0, w_seen = 0;
  bit          hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
  logic [31:0] wa = '0, wd = '0, ra = '0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_prot = '0;
  int          w_before_aw = 0;
  int          bad_bready = 0;

  // Slave drives on the falling edge; hs_* record handshakes due at the next rising edge
  always @(negedge tb_ACLK) begin
    if (!ARESETN) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0;  M_AXI_RVALID = 0;
      aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    end else begin
      if (hs_aw) aw_seen = 1;
      if (hs_w)  w_seen  = 1;
      if (hs_b)  M_AXI_BVALID = 0;
      if (hs_r)  M_AXI_RVALID = 0;
      if (hs_ar) begin
        M_AXI_RVALID = 1; M_AXI_RDATA = mem[ra[7:2]]; M_AXI_RRESP = xresp;
      end
      if (aw_seen && w_seen && !M_AXI_BVALID && !b_hold) begin
        mem[wa[7:2]] = wd; M_AXI_BVALID = 1; M_AXI_BRESP = xresp;
        aw_seen = 0; w_seen = 0;
      end
      if (M_AXI_AWVALID) begin
        if (aw_cnt >= aw_dly) M_AXI_AWREADY = 1;
        else begin M_AXI_AWREADY = 0; aw_cnt++; end
      end else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
      if (M_AXI_WVALID) begin
        if (w_cnt >= w_dly) M_AXI_WREADY = 1;
        else begin M_AXI_WREADY = 0; w_cnt++; end
      end else begin M_AXI_WREADY = 0; w_cnt = 0; end
      M_AXI_ARREADY = M_AXI_ARVALID;
      hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
      hs_w  = M_AXI_WVALID && M_AXI_WREADY;
      hs_b  = M_AXI_BVALID && M_AXI_BREADY;
      hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
      hs_r  = M_AXI_RVALID && M_AXI_RREADY;
      if (hs_aw) begin wa = M_AXI_AWADDR; cap_awaddr = M_AXI_AWADDR; cap_prot = M_AXI_AWPROT; end
      if (hs_w)  begin wd = M_AXI_WDATA; cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; end
      if (hs_ar) begin ra = M_AXI_ARADDR; cap_araddr = M_AXI_ARADDR; end
      if (M_AXI_AWVALID && !M_AXI_WVALID) w_before_aw++;
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID || M_AXI_RREADY))
        bad_bready++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_rdata = '0;
  int          done_pulses = 0;

  // Every done pulse must match the oldest outstanding expectation
  always @(negedge tb_ACLK) begin
    if (req_done != '0) begin
      exp_t e;
      done_pulses++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got 0x%0h expected none", req_done);
      end else begin
        e = sb.pop_front();
        chk("done_idx", 64'(req_done), 64'(oh(e.idx)));
        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge tb_ACLK); n++; end while (req_done == '0 && n < 50);
    if (req_done == '0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    do begin @(negedge tb_ACLK); n++; end while (req_grant == '0 && n < 20);
    if (req_grant == '0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no grant expected grant", name);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_we[i] = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_d;
    int          w_d;
    logic [1:0]  slv_resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    exp_t e;
    aw_dly = v.aw_d; w_dly = v.w_d; xresp = v.slv_resp; w_before_aw = 0;
    if (!v.we) model_rdata = v.exp_rdata;
    e.idx = v.idx; e.rdata = model_rdata; e.resp = v.exp_resp;
    sb.push_back(e);
    set_req(v.idx, v.we, v.addr, v.wdata);
    req_valid = oh(v.idx);
    @(negedge tb_ACLK);
    chk("grant", 64'(req_grant), 64'(oh(v.idx)));
    chk("valids_at_grant", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}),
        v.we ? 64'(3'b110) : 64'(3'b001));
    req_valid = '0;
    wait_done("vec_done");
    @(negedge tb_ACLK);
    chk("done_pulse", 64'(req_done), 64'h0);
    if (v.we) begin
      chk("awaddr", 64'(cap_awaddr), 64'(v.addr));
      chk("wdata", 64'(cap_wdata), 64'(v.wdata));
      chk("wstrb", 64'(cap_wstrb), 64'hF);
      chk("awprot", 64'(cap_prot), 64'h0);
      if (v.aw_d > v.w_d) chk("w_before_aw", 64'(w_before_aw > 0), 64'h1);
    end else begin
      chk("araddr", 64'(cap_araddr), 64'(v.addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [4];
    exp_t e;
`ifdef NASH_AXIL_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 64; i++) mem[i] = '0;
    //          idx we    addr   wdata         awd wd resp   exp_rdata     exp_resp
    vecs[0] = '{0, 1'b1, 32'h00, 32'h0101FFFF, 0, 0, 2'b00, 32'h0,        2'b00};
    vecs[1] = '{1, 1'b0, 32'h00, 32'h0,        0, 0, 2'b00, 32'h0101FFFF, 2'b00};
    vecs[2] = '{0, 1'b1, 32'h04, 32'habcd0001, 3, 0, 2'b00, 32'h0,        2'b00};
    vecs[3] = '{0, 1'b1, 32'h08, 32'h12345678, 0, 2, 2'b11, 32'h0,        2'b11};
    vecs[4] = '{1, 1'b0, 32'h0C, 32'h0,        0, 0, 2'b10, 32'h0,        2'b10};
    vecs[5] = '{1, 1'b0, 32'h04, 32'h0,        0, 0, 2'b00, 32'habcd0001, 2'b00};

    ARESETN = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge tb_ACLK);
    chk("rst_grant_done", 64'({req_grant, req_done}), 64'h0);
    chk("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'h0);
    chk("rst_axi", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'h0);
    ARESETN = 1'b1;
    @(negedge tb_ACLK);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Both requesters held high for four transactions
    aw_dly = 0; w_dly = 0; xresp = 2'b00;
    set_req(0, 1'b1, 32'h10, 32'hdead0011);
    set_req(1, 1'b1, 32'h14, 32'hbeef0011);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.idx = exp_order[k]; e.rdata = model_rdata; e.resp = 2'b00;
      sb.push_back(e);
      wait_grant("held_grant");
      chk("held_grant", 64'(req_grant), 64'(oh(exp_order[k])));
      if (k > 0) chk("held_done_pulse", 64'(req_done), 64'h0);
      if (k == 3) req_valid = '0;
      wait_done("held_done");
    end
    @(negedge tb_ACLK);

    // Reset asserted while a write sits in WR_RESP
    b_hold = 1'b1;
    set_req(0, 1'b1, 32'h20, 32'h5555aaaa);
    req_valid = 2'b01;
    @(negedge tb_ACLK);
    chk("stuck_grant", 64'(req_grant), 64'(2'b01));
    req_valid = '0;
    for (int n = 0; n < 20 && !M_AXI_BREADY; n++) @(negedge tb_ACLK);
    chk("stuck_bready", 64'(M_AXI_BREADY), 64'h1);
    ARESETN = 1'b0;
    #1;
    chk("midrst_axi", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'h0);
    chk("midrst_done", 64'(req_done), 64'h0);
    repeat (2) @(negedge tb_ACLK);
    chk("midrst_rsp", 64'({rsp_rdata, rsp_resp}), 64'h0);
    b_hold = 1'b0;
    ARESETN = 1'b1;
    set_req(0, 1'b0, 32'h00, 32'h0);
    set_req(1, 1'b0, 32'h04, 32'h0);
    model_rdata = 32'h0101FFFF;
    e.idx = 0; e.rdata = model_rdata; e.resp = 2'b00;
    sb.push_back(e);
    req_valid = 2'b11;
    @(negedge tb_ACLK);
    chk("post_rst_grant", 64'(req_grant), 64'(2'b01));
    req_valid = '0;
    wait_done("post_rst_done");
    @(negedge tb_ACLK);
    chk("post_rst_pulse", 64'(req_done), 64'h0);
    repeat (3) @(negedge tb_ACLK);

    chk("bready_only_wr_resp", 64'(bad_bready), 64'h0);
    chk("done_count", 64'(done_pulses), 64'd11);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nash_axil_arbiter.md
Name: nash_axil_arbiter

Overview:
- Shares the single AXI4-Lite master path into the NASH_SYSTEM S00_AXI register slave among NREQ on-chip requesters, e.g. the PS config path and the spike/LIF scheduler.
- Each requester presents a single-beat read or write on a simple valid/grant/done interface.
- The block arbitrates between requesters, sequences the AXI4-Lite channel handshakes, and returns read data and response to the granted requester.
- Exactly one outstanding AXI transaction at any time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; WSTRB width = DATA_W/8.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- req_grant  out  NREQ  one-cycle pulse: request accepted and latched.
- req_done  out  NREQ  one-cycle pulse: transaction complete.
- rsp_rdata  out  DATA_W  read data of last completed read.
- rsp_resp  out  2  BRESP/RRESP of last completed transaction.
- M_AXI_AWADDR  out  ADDR_W;  M_AXI_AWPROT  out  3;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1.
- M_AXI_WDATA  out  DATA_W;  M_AXI_WSTRB  out  DATA_W/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1.
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1.
- M_AXI_ARADDR  out  ADDR_W;  M_AXI_ARPROT  out  3;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  DATA_W;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1.

Behaviour:
- One clock, ACLK. Reset is asynchronous, active-low, on ARESETN.
- Reset values:
  - All outputs 0.
  - FSM = IDLE.
  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
- AWPROT/ARPROT are always 3'b000. WSTRB is all ones.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE, when any req_valid bit is set at cycle T:
  - Winner = first set bit searching last+1, last+2, ... (mod NREQ).
  - Latch that requester's addr, wdata and we.
  - last <= winner.
  - At T+1: req_grant[winner] = 1 for one cycle, and the channel valids are asserted.
  - The requester must hold its fields stable through cycle T. It must drop or change req_valid after seeing grant; req_valid held high is treated as a new request.
- WR_ADDR_DATA:
  - AWVALID and WVALID assert together.
  - Each deasserts on the cycle after its own ready is sampled high; AW and W complete independently and in either order.
  - When both have completed -> WR_RESP.
- WR_RESP:
  - BREADY = 1.
  - On BVALID: rsp_resp <= BRESP, req_done[winner] pulses next cycle, -> IDLE.
- RD_ADDR: ARVALID = 1 until ARREADY, then -> RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: rsp_rdata <= RDATA, rsp_resp <= RRESP, req_done pulses next cycle, -> IDLE.
- Addresses and data stay stable while their valid is high. A valid never drops before its ready.
- rsp_rdata and rsp_resp hold until the next completion. A write leaves rsp_rdata unchanged.
- At least one IDLE cycle separates transactions. Arbitration samples req_valid only in IDLE.
- A requester dropping req_valid before grant is simply not served; no grant, no error.
- SLVERR/DECERR responses are forwarded as-is; no retry.
- ARESETN asserted mid-transaction: all valids/readies drop immediately, the FSM returns to IDLE, and no done is issued. The pointer resets to NREQ-1.

Optional Feature:
- Macro: NASH_AXIL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requester with req_valid wins and the pointer is unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Write via requester 0, addr 0x00, data 0x0101FFFF, slave ready immediately:
  - grant[0] at T+1.
  - AWADDR=0x00, WDATA=0x0101FFFF, WSTRB=0xF.
  - done[0] one cycle after the B handshake; rsp_resp=00.
- Read back addr 0x00 via requester 1:
  - ARADDR=0x00.
  - done[1] pulses; rsp_rdata=0x0101FFFF, rsp_resp=00.
- Write 0xabcd0001 to 0x04; slave gives AWREADY 3 cycles after WREADY:
  - WVALID drops first, AWVALID holds until its ready.
  - A single done; BREADY is high only in WR_RESP.
- Both req_valid held high for 4 transactions (0xdead0011, 0xbeef0011, ...):
  - Default build: grant order 0,1,0,1.
  - With NASH_AXIL_ARB_FIXED_PRIO_EN: order 0,0,0,0.
- Slave returns RRESP=2'b10 on a read of 0x0C -> rsp_resp=10 and done still pulses once.
- ARESETN pulled low while in WR_RESP:
  - All AXI valids and BREADY go 0 immediately; no done.
  - After release, a new request from requester 0 is granted first.
